ps2_keyboard: RTL and testbench

Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins and produces the `keycode`, `make` and `keycode_ready` signals that the Simon datapath consumes. The block handles the F0 (break) and E0 (extended) prefixes, so the downstream logic sees exactly one event per key press or release. It is device-to-host only and never drives the PS/2 lines. It sits between the board pins and the datapath and runs in the 50 MHz `clk` domain.

---
 rtl/ps2_keyboard.sv | 207 ++++++++++++++++++++
 tb/tb_ps2_keyboard.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard.sv
`timescale 1ns/1ps
// ps2_keyboard
// Device-to-host PS/2 keyboard receiver for the Simon datapath. Decodes
// 11-bit PS/2 frames from the raw pins and folds the E0 (extended) and
// F0 (break) prefixes into a single event per key press or release.
// The PS/2 lines are only ever sampled, never driven.
//
// Ports:
//   clk           system clock (50 MHz), the only clock
//   reset         synchronous, active-high
//   ps2_clk       raw PS/2 clock pin (asynchronous)
//   ps2_data      raw PS/2 data pin (asynchronous)
//   keycode       last decoded scan code, prefixes stripped
//   make          1 = press, 0 = release
//   extended      1 = code was preceded by E0
//   keycode_ready one-cycle pulse, keycode/make/extended valid with it
//   frame_error   one-cycle pulse on parity, stop-bit or timeout failure
module ps2_keyboard #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       make,
    output logic       extended,
    output logic       keycode_ready,
    output logic       frame_error
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Two-flop synchronizers; reset high to match an idle bus.
    logic clk_meta, clk_sync;
    logic data_meta, data_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_sync  <= clk_meta;
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    // Glitch filter: the filtered level only changes once the whole sample
    // window agrees, so short spikes on the cable clock are ignored.
    logic [FILTER_LEN-1:0] filt_sr;
    logic                  clk_filt;
    logic                  clk_filt_d1;
    logic                  fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_sr     <= '1;
            clk_filt    <= 1'b1;
            clk_filt_d1 <= 1'b1;
        end else begin
            filt_sr     <= {filt_sr[FILTER_LEN-2:0], clk_sync};
            clk_filt_d1 <= clk_filt;
            if (&filt_sr) begin
                clk_filt <= 1'b1;
            end else if (~|filt_sr) begin
                clk_filt <= 1'b0;
            end
        end
    end

    assign fall = clk_filt_d1 & ~clk_filt;

    // Receiver state.
    state_t        state, state_next;
    logic [3:0]    bit_cnt, bit_cnt_next;
    logic [7:0]    shift_reg, shift_next;
    logic          parity_bit, parity_next;
    logic [TW-1:0] timeout_cnt, timeout_next;
    logic          brk, brk_next;
    logic          ext, ext_next;
    logic [7:0]    keycode_next;
    logic          make_next, extended_next;
    logic          ready_next, error_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            parity_bit    <= 1'b0;
            timeout_cnt   <= '0;
            brk           <= 1'b0;
            ext           <= 1'b0;
            keycode       <= 8'h00;
            make          <= 1'b0;
            extended      <= 1'b0;
            keycode_ready <= 1'b0;
            frame_error   <= 1'b0;
        end else begin
            state         <= state_next;
            bit_cnt       <= bit_cnt_next;
            shift_reg     <= shift_next;
            parity_bit    <= parity_next;
            timeout_cnt   <= timeout_next;
            brk           <= brk_next;
            ext           <= ext_next;
            keycode       <= keycode_next;
            make          <= make_next;
            extended      <= extended_next;
            keycode_ready <= ready_next;
            frame_error   <= error_next;
        end
    end

    // Next-state logic. Outputs are computed here and registered above, so
    // the pulses appear one cycle after the deciding fall or timeout.
    // The timeout fires on the TIMEOUT-th cycle after the last fall
    // without another fall arriving.
    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift_reg;
        parity_next   = parity_bit;
        timeout_next  = timeout_cnt;
        brk_next      = brk;
        ext_next      = ext;
        keycode_next  = keycode;
        make_next     = make;
        extended_next = extended;
        ready_next    = 1'b0;
        error_next    = 1'b0;

        if (state != IDLE) begin
            if (fall) begin
                timeout_next = '0;
            end else if (timeout_cnt != TW'(TIMEOUT)) begin
                timeout_next = timeout_cnt + TW'(1);
            end
        end else begin
            timeout_next = '0;
        end

        if ((state != IDLE) && !fall && (timeout_cnt == TW'(TIMEOUT - 1))) begin
            state_next   = IDLE;
            timeout_next = '0;
            error_next   = 1'b1;
            brk_next     = 1'b0;
            ext_next     = 1'b0;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!data_sync) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    shift_next = {data_sync, shift_reg[7:1]};
                    if (bit_cnt == 4'd7) begin
                        state_next = PARITY;
                    end else begin
                        bit_cnt_next = bit_cnt + 4'd1;
                    end
                end
                PARITY: begin
                    parity_next = data_sync;
                    state_next  = STOP;
                end
                STOP: begin
                    state_next = IDLE;
                    if ((^{shift_reg, parity_bit}) && data_sync) begin
                        if (shift_reg == 8'hE0) begin
                            ext_next = 1'b1;
                        end else if (shift_reg == 8'hF0) begin
                            brk_next = 1'b1;
                        end else begin
                            keycode_next  = shift_reg;
                            make_next     = !brk;
                            extended_next = ext;
                            ready_next    = 1'b1;
                            brk_next      = 1'b0;
                            ext_next      = 1'b0;
                        end
                    end else begin
                        error_next = 1'b1;
                        brk_next   = 1'b0;
                        ext_next   = 1'b0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
`timescale 1ns/1ps
// tb_ps2_keyboard
// Directed bench for ps2_keyboard. Expected key events go onto a
// scoreboard queue as frames are sent; a monitor pops and compares them
// whenever keycode_ready pulses. Frame errors are counted separately.
module tb_ps2_keyboard;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1000;
    localparam int HALF       = 60;
    localparam int DETECT_LAT = 2 + FILTER_LEN + 1;

    typedef struct {
        logic [7:0] code;
        logic       mk;
        logic       ext;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic       make;
    logic       extended;
    logic       keycode_ready;
    logic       frame_error;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   obs_err  = 0;
    int   exp_err  = 0;
    int   last_fall_cyc  = 0;
    int   last_ready_cyc = -1;
    int   last_err_cyc   = -1;
    logic prev_ready = 1'b0;
    logic prev_err   = 1'b0;

    ps2_keyboard #(
        .FILTER_LEN(FILTER_LEN),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .keycode      (keycode),
        .make         (make),
        .extended     (extended),
        .keycode_ready(keycode_ready),
        .frame_error  (frame_error)
    );

    // 100 MHz bench clock; only the relative cycle count matters.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single comparison point: counts every check and reports failures.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Sends the first nbits of a PS/2 frame; data changes while the clock
    // is high and the line clock falls mid-bit.
    task automatic applyStimulus(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] frame;
        frame = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = frame[i];
            repeat (HALF / 2) @(negedge clk);
            ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (HALF / 2) @(negedge clk);
        end
    endtask

    task automatic pushExp(input logic [7:0] code, input logic mk, input logic ext);
        exp_t e;
        e.code = code;
        e.mk   = mk;
        e.ext  = ext;
        sb.push_back(e);
    endtask

    // Monitor: scoreboard compare on every ready pulse, plus pulse shape.
    always @(negedge clk) begin
        if (!reset) begin
            if (keycode_ready || frame_error) begin
                checkOutput("ready_err_overlap", 32'(keycode_ready && frame_error), 32'd0);
            end
            if (keycode_ready) begin
                exp_t e;
                last_ready_cyc = cyc;
                checkOutput("ready_width", 32'(prev_ready), 32'd0);
                checkOutput("ready_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checkOutput("keycode", 32'(keycode), 32'(e.code));
                    checkOutput("make", 32'(make), 32'(e.mk));
                    checkOutput("extended", 32'(extended), 32'(e.ext));
                end
            end
            if (frame_error) begin
                obs_err++;
                last_err_cyc = cyc;
                checkOutput("error_width", 32'(prev_err), 32'd0);
            end
        end
        prev_ready = keycode_ready;
        prev_err   = frame_error;
    end

    // Watchdog so the bench can never hang.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("rst_keycode", 32'(keycode), 32'h00);
        checkOutput("rst_make", 32'(make), 32'd0);
        checkOutput("rst_extended", 32'(extended), 32'd0);
        checkOutput("rst_ready", 32'(keycode_ready), 32'd0);
        checkOutput("rst_error", 32'(frame_error), 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] press 1C");
        pushExp(8'h1C, 1'b1, 1'b0);
        applyStimulus(8'h1C, 1'b0, 11);
        checkOutput("press_latency", 32'(last_ready_cyc - last_fall_cyc), 32'(DETECT_LAT + 1));

        $display("[TB] release F0 1C");
        applyStimulus(8'hF0, 1'b0, 11);
        pushExp(8'h1C, 1'b0, 1'b0);
        applyStimulus(8'h1C, 1'b0, 11);

        $display("[TB] extended release E0 F0 75, then 1C");
        applyStimulus(8'hE0, 1'b0, 11);
        applyStimulus(8'hF0, 1'b0, 11);
        pushExp(8'h75, 1'b0, 1'b1);
        applyStimulus(8'h75, 1'b0, 11);
        pushExp(8'h1C, 1'b1, 1'b0);
        applyStimulus(8'h1C, 1'b0, 11);

        $display("[TB] typematic repeat 1C");
        pushExp(8'h1C, 1'b1, 1'b0);
        applyStimulus(8'h1C, 1'b0, 11);

        $display("[TB] bad parity 1C");
        exp_err++;
        applyStimulus(8'h1C, 1'b1, 11);
        checkOutput("badpar_err_count", 32'(obs_err), 32'(exp_err));
        checkOutput("badpar_err_latency", 32'(last_err_cyc - last_fall_cyc), 32'(DETECT_LAT + 1));
        checkOutput("badpar_hold_keycode", 32'(keycode), 32'h1C);
        checkOutput("badpar_hold_make", 32'(make), 32'd1);
        pushExp(8'h1C, 1'b1, 1'b0);
        applyStimulus(8'h1C, 1'b0, 11);

        $display("[TB] 5-cycle glitch on ps2_clk");
        @(negedge clk);
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk  = 1'b1;
        repeat (TIMEOUT + 100) @(negedge clk);
        checkOutput("glitch_no_error", 32'(obs_err), 32'(exp_err));
        ps2_data = 1'b1;

        $display("[TB] timeout after 4 data bits");
        exp_err++;
        applyStimulus(8'hA5, 1'b0, 5);
        repeat (TIMEOUT + 100) @(negedge clk);
        checkOutput("timeout_err_count", 32'(obs_err), 32'(exp_err));
        checkOutput("timeout_latency", 32'(last_err_cyc - last_fall_cyc), 32'(DETECT_LAT + TIMEOUT + 1));
        pushExp(8'h29, 1'b1, 1'b0);
        applyStimulus(8'h29, 1'b0, 11);

        $display("[TB] reset mid-frame of F0");
        applyStimulus(8'hF0, 1'b0, 6);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("midrst_keycode", 32'(keycode), 32'h00);
        checkOutput("midrst_make", 32'(make), 32'd0);
        checkOutput("midrst_extended", 32'(extended), 32'd0);
        checkOutput("midrst_ready", 32'(keycode_ready), 32'd0);
        checkOutput("midrst_error", 32'(frame_error), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("midrst_err_count", 32'(obs_err), 32'(exp_err));
        pushExp(8'h1C, 1'b1, 1'b0);
        applyStimulus(8'h1C, 1'b0, 11);

        repeat (50) @(negedge clk);
        checkOutput("final_err_count", 32'(obs_err), 32'(exp_err));
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
